// File: rtl/b2m_ps2_rx.sv
// b2m_ps2_rx: PS/2 device-to-host receiver for the Bashkiria-2M keyboard path.
// Synchronises and deglitches ps2_clk/ps2_dat, deframes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop), recovers from stalled frames
// and queues accepted scan codes in a show-ahead FIFO.
//
// Optional feature macro: B2M_PS2_PREFIX_EN
//   defined   - E0/F0 bytes are absorbed as ext/brk prefix flags that are
//               attached to the next accepted code.
//   undefined - every accepted byte is queued raw; ext/brk are always 0.
//
// Handshake: valid is high while the FIFO holds an entry and code/ext/brk
// show the head entry. A cycle with rd=1 and valid=1 pops that entry; the
// next entry (or valid=0) is visible one cycle later. rd with valid=0 is a
// no-op. err and overflow are single-cycle pulses.
//
// dbg_state exposes the frame FSM state (0 IDLE, 1 DATA, 2 PARITY, 3 STOP).

module b2m_ps2_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 25000,
  parameter int FIFO_AW     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  output logic       valid,
  output logic [7:0] code,
  output logic       ext,
  output logic       brk,
  output logic       err,
  output logic       overflow,
  output logic [1:0] dbg_state
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic                  clk_s1_q, clk_s_q;
  logic                  dat_s1_q, dat_s_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q;
  logic                  all_ones, all_zeros;
  logic                  fall;

  // Two-flop synchronisers; lines idle high so they reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s_q  <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s_q  <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s_q  <= clk_s1_q;
      dat_s1_q <= ps2_dat;
      dat_s_q  <= dat_s1_q;
    end
  end

  assign hist_d    = {hist_q[FILTER_LEN-2:0], clk_s_q};
  assign all_ones  = &hist_q;
  assign all_zeros = ~|hist_q;
  // A sample event is the single cycle in which the filtered clock drops.
  assign fall      = filt_q & all_zeros;

  // Deglitch filter: the clock only changes after FILTER_LEN equal samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
      if (all_ones) begin
        filt_q <= 1'b1;
      end else if (all_zeros) begin
        filt_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_e          state_q;
  logic [2:0]      bitcnt_q;
  logic [7:0]      shreg_q;
  logic            par_q;
  logic [TW-1:0]   tmo_q;
  logic            err_q;
  logic            acc_q;
  logic [7:0]      acc_byte_q;

  // Deframer: advances on sample events, aborts a stalled frame on timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      shreg_q    <= 8'd0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      acc_q      <= 1'b0;
      acc_byte_q <= 8'd0;
    end else begin
      err_q <= 1'b0;
      acc_q <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        case (state_q)
          ST_IDLE: begin
            // A high data bit here is a spurious edge, not a start bit.
            if (!dat_s_q) begin
              state_q  <= ST_DATA;
              bitcnt_q <= 3'd0;
            end
          end
          ST_DATA: begin
            shreg_q <= {dat_s_q, shreg_q[7:1]};
            if (bitcnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end else begin
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end
          ST_PARITY: begin
            par_q   <= dat_s_q;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (dat_s_q && ((^shreg_q) ^ par_q)) begin
              acc_q      <= 1'b1;
              acc_byte_q <= shreg_q;
            end else begin
              err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE) begin
        if (tmo_q == TMO_LAST) begin
          state_q <= ST_IDLE;
          err_q   <= 1'b1;
          tmo_q   <= '0;
        end else begin
          tmo_q <= tmo_q + TW'(1);
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign err       = err_q;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------
  // Prefix handling and FIFO
  // ---------------------------------------------------------------------
  logic [FIFO_AW:0]   wptr_q, rptr_q;
  logic [9:0]         mem_q [DEPTH];
  logic [9:0]         head;
  logic               empty, full;
  logic               pop, do_push, wr_en, drop;
  logic               wr_ext, wr_brk;
  logic               ovf_q;

`ifdef B2M_PS2_PREFIX_EN
  logic ext_pend_q, brk_pend_q;
  logic is_prefix;

  assign is_prefix = (acc_byte_q == 8'hE0) || (acc_byte_q == 8'hF0);
  assign wr_ext    = ext_pend_q;
  assign wr_brk    = brk_pend_q;
`else
  logic is_prefix;

  assign is_prefix = 1'b0;
  assign wr_ext    = 1'b0;
  assign wr_brk    = 1'b0;
`endif

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                   (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign pop     = rd & ~empty;
  assign do_push = acc_q & ~is_prefix;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign wr_en   = do_push & (~full | pop);
  assign drop    = do_push & full & ~pop;

  // FIFO pointers, overflow pulse and prefix flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
`ifdef B2M_PS2_PREFIX_EN
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
`endif
    end else begin
      ovf_q <= drop;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (wr_en) begin
        wptr_q <= wptr_q + 1'b1;
      end
`ifdef B2M_PS2_PREFIX_EN
      if (err_q || drop) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else if (acc_q) begin
        if (acc_byte_q == 8'hE0) begin
          ext_pend_q <= 1'b1;
        end else if (acc_byte_q == 8'hF0) begin
          brk_pend_q <= 1'b1;
        end else begin
          ext_pend_q <= 1'b0;
          brk_pend_q <= 1'b0;
        end
      end
`endif
    end
  end

  // Storage array; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[FIFO_AW-1:0]] <= {wr_ext, wr_brk, acc_byte_q};
    end
  end

  assign head     = mem_q[rptr_q[FIFO_AW-1:0]];
  assign valid    = ~empty;
  assign code     = valid ? head[7:0] : 8'd0;
  assign ext      = valid & head[9];
  assign brk      = valid & head[8];
  assign overflow = ovf_q;

endmodule

// File: tb/tb_b2m_ps2_rx.sv
// Directed testbench for b2m_ps2_rx (FILTER_LEN=4, TIMEOUT_CYC=200, FIFO_AW=2).
// PS/2 half period is 20 system clocks. Expectations for prefix handling
// follow B2M_PS2_PREFIX_EN.

module tb_b2m_ps2_rx;

  localparam int H = 20;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd = 1'b0;
  logic       valid;
  logic [7:0] code;
  logic       ext;
  logic       brk;
  logic       err;
  logic       overflow;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  b2m_ps2_rx #(
    .FILTER_LEN (4),
    .TIMEOUT_CYC(200),
    .FIFO_AW    (2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rd       (rd),
    .valid    (valid),
    .code     (code),
    .ext      (ext),
    .brk      (brk),
    .err      (err),
    .overflow (overflow),
    .dbg_state(dbg_state)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (err) err_cnt++;
    if (overflow) ovf_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par);
    logic p;
    p = (~^d) ^ bad_par;
    return {1'b1, p, d, 1'b0};
  endfunction

  // Sends the first nbits of a frame; optional 1-cycle low glitch in each high phase.
  task automatic send_bits(input logic [7:0] d, input bit bad_par, input int nbits, input bit glitch);
    logic [10:0] f;
    f = mk_frame(d, bad_par);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      if (glitch) begin
        cyc(8);
        ps2_clk = 1'b0;
        cyc(1);
        ps2_clk = 1'b1;
        cyc(H - 9);
      end else begin
        cyc(H);
      end
      ps2_clk = 1'b0;
      cyc(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d);
    send_bits(d, 1'b0, 11, 1'b0);
    cyc(2 * H);
  endtask

  // Observes the head entry then pops it.
  task automatic pop_obs(output logic v, output logic [7:0] c, output logic e, output logic b);
    @(negedge clk);
    v = valid;
    c = code;
    e = ext;
    b = brk;
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #2 reset_n = 1'b0;
    cyc(5);
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code got %h exp 00", code); end
    checks++; if (ext !== 1'b0) begin errors++; $display("FAIL reset_ext got %b exp 0", ext); end
    checks++; if (brk !== 1'b0) begin errors++; $display("FAIL reset_brk got %b exp 0", brk); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    reset_n = 1'b1;
    cyc(10);
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
  endtask

  task automatic test_basic;
    int lat;
    int e0;
    e0 = err_cnt;
    lat = -1;
    send_bits(8'h1C, 1'b0, 10, 1'b0);
    ps2_dat = 1'b1;
    cyc(H);
    ps2_clk = 1'b0;
    // raw edge -> 2 sync + 4 filter -> sample; +1 push, +1 valid => about 8
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (valid) begin
        lat = n;
        break;
      end
    end
    checks++; if (lat < 6 || lat > 10) begin errors++; $display("FAIL basic_latency got %0d exp 6..10", lat); end
    cyc(H);
    ps2_clk = 1'b1;
    cyc(H);
    @(negedge clk);
    checks++; if (code !== 8'h1C) begin errors++; $display("FAIL basic_code got %h exp 1c", code); end
    checks++; if (ext !== 1'b0 || brk !== 1'b0) begin errors++; $display("FAIL basic_flags got %b%b exp 00", ext, brk); end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL basic_err got %0d exp 0", err_cnt - e0); end
    rd = 1'b1;
    @(posedge clk);
    #1;
    rd = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b exp 0", valid); end
    // rd with empty FIFO is ignored
    rd = 1'b1;
    cyc(2);
    rd = 1'b0;
    send_frame(8'h21);
    @(negedge clk);
    checks++; if (valid !== 1'b1 || code !== 8'h21) begin errors++; $display("FAIL basic_rd_empty got %b/%h exp 1/21", valid, code); end
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  task automatic test_prefix;
    logic v;
    logic [7:0] c;
    logic e, b;
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);
`ifdef B2M_PS2_PREFIX_EN
    pop_obs(v, c, e, b);
    checks++; if ({v, c, e, b} !== {1'b1, 8'h75, 1'b1, 1'b1}) begin errors++; $display("FAIL prefix_entry got v%b %h e%b b%b exp v1 75 e1 b1", v, c, e, b); end
`else
    pop_obs(v, c, e, b);
    checks++; if ({v, c, e, b} !== {1'b1, 8'hE0, 1'b0, 1'b0}) begin errors++; $display("FAIL raw_entry0 got v%b %h e%b b%b exp v1 e0 e0 b0", v, c, e, b); end
    pop_obs(v, c, e, b);
    checks++; if ({v, c, e, b} !== {1'b1, 8'hF0, 1'b0, 1'b0}) begin errors++; $display("FAIL raw_entry1 got v%b %h e%b b%b exp v1 f0 e0 b0", v, c, e, b); end
    pop_obs(v, c, e, b);
    checks++; if ({v, c, e, b} !== {1'b1, 8'h75, 1'b0, 1'b0}) begin errors++; $display("FAIL raw_entry2 got v%b %h e%b b%b exp v1 75 e0 b0", v, c, e, b); end
`endif
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL prefix_empty got %b exp 0", valid); end
  endtask

  task automatic test_parity_err;
    logic v;
    logic [7:0] c;
    logic e, b;
    int e0;
    e0 = err_cnt;
    send_bits(8'h1C, 1'b1, 11, 1'b0);
    cyc(2 * H);
    @(negedge clk);
    checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL parity_err_pulse got %0d exp 1", err_cnt - e0); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL parity_no_push got %b exp 0", valid); end
    send_frame(8'h16);
    pop_obs(v, c, e, b);
    checks++; if ({v, c, e, b} !== {1'b1, 8'h16, 1'b0, 1'b0}) begin errors++; $display("FAIL parity_next got v%b %h e%b b%b exp v1 16 e0 b0", v, c, e, b); end
  endtask

  task automatic test_timeout;
    logic v;
    logic [7:0] c;
    logic e, b;
    int lat;
    int e0;
    logic [1:0] mid_state;
    e0 = err_cnt;
    lat = -1;
    mid_state = S_IDLE;
    send_bits(8'h00, 1'b0, 3, 1'b0);
    ps2_dat = 1'b0;
    cyc(H);
    ps2_clk = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == H) ps2_clk = 1'b1;
      if (n == 100) mid_state = dbg_state;
      if (err) begin
        lat = n;
        break;
      end
    end
    ps2_dat = 1'b1;
    // sample ~7 cycles after the raw edge, then 199 counts, then err
    checks++; if (mid_state !== S_DATA) begin errors++; $display("FAIL timeout_mid_state got %0d exp 1", mid_state); end
    checks++; if (lat < 198 || lat > 216) begin errors++; $display("FAIL timeout_latency got %0d exp 198..216", lat); end
    @(negedge clk);
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL timeout_state got %0d exp 0", dbg_state); end
    cyc(5);
    checks++; if (err_cnt - e0 != 1 || valid !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %0d/%b exp 1/0", err_cnt - e0, valid); end
    send_frame(8'h29);
    pop_obs(v, c, e, b);
    checks++; if ({v, c} !== {1'b1, 8'h29}) begin errors++; $display("FAIL timeout_next got v%b %h exp v1 29", v, c); end
  endtask

  task automatic test_overflow;
    logic v;
    logic [7:0] c;
    logic e, b;
    logic [7:0] codes [5];
    int o0;
    codes[0] = 8'h11; codes[1] = 8'h22; codes[2] = 8'h33; codes[3] = 8'h44; codes[4] = 8'h55;
    o0 = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      send_frame(codes[i]);
      @(negedge clk);
      checks++; if (ovf_cnt - o0 != ((i == 4) ? 1 : 0)) begin errors++; $display("FAIL overflow_after_%0d got %0d exp %0d", i, ovf_cnt - o0, (i == 4) ? 1 : 0); end
    end
    for (int i = 0; i < 4; i++) begin
      pop_obs(v, c, e, b);
      checks++; if ({v, c} !== {1'b1, codes[i]}) begin errors++; $display("FAIL overflow_pop%0d got v%b %h exp v1 %h", i, v, c, codes[i]); end
    end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL overflow_empty got %b exp 0", valid); end
  endtask

  task automatic test_glitch;
    logic v;
    logic [7:0] c;
    logic e, b;
    int e0;
    e0 = err_cnt;
    send_bits(8'h3A, 1'b0, 11, 1'b1);
    cyc(2 * H);
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL glitch_err got %0d exp 0", err_cnt - e0); end
    pop_obs(v, c, e, b);
    checks++; if ({v, c} !== {1'b1, 8'h3A}) begin errors++; $display("FAIL glitch_code got v%b %h exp v1 3a", v, c); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_extra got %b exp 0", valid); end
  endtask

  task automatic test_reset_mid;
    logic v;
    logic [7:0] c;
    logic e, b;
    send_frame(8'h12);
    send_bits(8'h34, 1'b0, 5, 1'b0);
    @(negedge clk);
    checks++; if (valid !== 1'b1 || dbg_state !== S_DATA) begin errors++; $display("FAIL rstmid_pre got %b/%0d exp 1/1", valid, dbg_state); end
    reset_n = 1'b0;
    cyc(3);
    @(negedge clk);
    checks++; if (valid !== 1'b0 || dbg_state !== S_IDLE) begin errors++; $display("FAIL rstmid_cleared got %b/%0d exp 0/0", valid, dbg_state); end
    reset_n = 1'b1;
    cyc(10);
    send_frame(8'h5A);
    pop_obs(v, c, e, b);
    checks++; if ({v, c, e, b} !== {1'b1, 8'h5A, 1'b0, 1'b0}) begin errors++; $display("FAIL rstmid_next got v%b %h e%b b%b exp v1 5a e0 b0", v, c, e, b); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_empty got %b exp 0", valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity_err();
    test_timeout();
    test_overflow();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
